// File: rtl/fsram_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsram_drain_pkg
// Description : Shared sizing constants and drain FSM state encoding for the
//               feature-SRAM drain engine.
// Revision    : 1.0 - initial release
// ============================================================================
package fsram_drain_pkg;

  // Number of 16-bit SRAM macros per feature bank.
  localparam int SRAM_NUM_DEF = 2;

  // Feature SRAM address width (2048 words).
  localparam int AW_DEF = 11;

  // Drain controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : fsram_drain_pkg
`default_nettype wire

// File: rtl/fsram_drain_fifo.sv
`default_nettype none
// ============================================================================
// Module      : drain_fifo
// Description : Two-entry FIFO buffering SRAM read data ahead of the DRAM
//               handshake. The head word is presented combinationally and
//               held until popped.
// Revision    : 1.0 - initial release
// ============================================================================
module drain_fifo #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    occ
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    occ_q, occ_d;
  logic          pop_ok;

  // A pop on an empty FIFO is meaningless; never let it move the pointers.
  assign pop_ok = pop && (occ_q != 2'd0);
  assign head   = mem_q[rd_ptr_q];
  assign occ    = occ_q;

  // Next-state: write at the tail, advance the head, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop_ok};
  end

  // Storage and pointer registers; reset clears data so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule : drain_fifo
`default_nettype wire

// File: rtl/fsram_drain.sv
`default_nettype none
// ============================================================================
// Module      : fsram_drain
// Description : Streams a contiguous block of words from one of two feature
//               SRAM banks to the DRAM side over a valid/ready handshake.
//               Reads are credit-limited so the 2-entry FIFO never overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module fsram_drain
  import fsram_drain_pkg::*;
#(
  parameter int SRAM_NUM = SRAM_NUM_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sram_sel,
  input  logic [AW-1:0]          base_addr,
  input  logic [AW:0]            word_cnt,
  output logic                   CENB_1,
  output logic                   CENB_2,
  output logic [AW-1:0]          AB,
  input  logic [SRAM_NUM*16-1:0] QB_1,
  input  logic [SRAM_NUM*16-1:0] QB_2,
  output logic [SRAM_NUM*16-1:0] data_o_DRAM,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy,
  output logic                   done
);

  localparam int DW = SRAM_NUM * 16;

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     rem_q, rem_d;
  logic            inflight_q, inflight_d;

  logic [1:0]      fifo_occ;
  logic [DW-1:0]   fifo_head;
  logic [DW-1:0]   rd_data;
  logic            pop;
  logic            credit_ok;
  logic            issue;

  // Handshake side is driven purely from FIFO state, never from ready_i.
  assign valid_o     = (fifo_occ != 2'd0);
  assign data_o_DRAM = fifo_head;
  assign pop         = valid_o && ready_i;

  // Words already buffered or in flight, less the one leaving now, must
  // leave room for one more so a read issued this cycle always has a slot.
  assign credit_ok = ({1'b0, fifo_occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  // Read data returns one cycle after issue from the bank latched at start.
  assign rd_data = sel_q ? QB_2 : QB_1;

  // Issue decision, FSM next-state and counter updates.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = sram_sel;
          addr_d  = base_addr;
          rem_d   = word_cnt;
          state_d = (word_cnt == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        issue = (rem_q != '0) && credit_ok;
        if (issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - (AW + 1)'(1);
          if (rem_q == (AW + 1)'(1)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (!inflight_q && (fifo_occ == 2'd0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    inflight_d = issue;
  end

  assign CENB_1 = !(issue && !sel_q);
  assign CENB_2 = !(issue && sel_q);
  assign AB     = addr_q;
  assign busy   = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done   = (state_q == ST_DONE);

  // Control registers; reset abandons any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
    end
  end

  drain_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .occ       (fifo_occ)
  );

endmodule : fsram_drain
`default_nettype wire

// File: tb/tb_fsram_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsram_drain
// Description : Self-checking bench for fsram_drain. Two behavioural SRAM
//               banks with one-cycle read latency feed the DUT; the expected
//               word stream is computed directly from bank contents and the
//               requested address range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsram_drain;
  import fsram_drain_pkg::*;

  localparam int AW    = AW_DEF;
  localparam int DW    = SRAM_NUM_DEF * 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sram_sel;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_cnt;
  logic          CENB_1, CENB_2;
  logic [AW-1:0] AB;
  logic [DW-1:0] QB_1 = '0;
  logic [DW-1:0] QB_2 = '0;
  logic [DW-1:0] data_o_DRAM;
  logic          valid_o;
  logic          ready_i;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic sel;
    int   base;
    int   cnt;
    int   rdy_pct;
    int   exp_done;   // expected done cycle, -1 when not timing-checked
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  // Behavioural SRAM banks: data appears the cycle after an enabled read.
  always @(posedge clk) begin
    if (!CENB_1) QB_1 <= mem1[AB];
    if (!CENB_2) QB_2 <= mem2[AB];
  end

  fsram_drain #(
    .SRAM_NUM (SRAM_NUM_DEF),
    .AW       (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sram_sel    (sram_sel),
    .base_addr   (base_addr),
    .word_cnt    (word_cnt),
    .CENB_1      (CENB_1),
    .CENB_2      (CENB_2),
    .AB          (AB),
    .QB_1        (QB_1),
    .QB_2        (QB_2),
    .data_o_DRAM (data_o_DRAM),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_at(input logic sel, input int addr);
    return sel ? mem2[addr] : mem1[addr];
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cenb1"}, 64'(CENB_1), 64'(1));
    chk({tag, "_cenb2"}, 64'(CENB_2), 64'(1));
    chk({tag, "_ab"},    64'(AB), 64'(0));
    chk({tag, "_valid"}, 64'(valid_o), 64'(0));
    chk({tag, "_data"},  64'(data_o_DRAM), 64'(0));
    chk({tag, "_busy"},  64'(busy), 64'(0));
    chk({tag, "_done"},  64'(done), 64'(0));
  endtask

  // One drain from start pulse (cycle 0) to two cycles after done.
  // mid_start_cyc >= 0 pulses a conflicting start during the drain;
  // rst_after >= 0 resets the DUT once that many words have been accepted.
  task automatic run_drain(input logic sel, input int base, input int cnt, input int rdy_pct,
                           input int exp_done, input int mid_start_cyc, input int rst_after);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_w;
    logic [DW-1:0] prev_data;
    int   reads = 0;
    int   pops = 0;
    int   dones = 0;
    int   done_cyc = -1;
    int   first_valid = -1;
    int   first_read = -1;
    int   last_read = -1;
    int   cyc = 0;
    int   budget;
    bit   prev_stall = 1'b0;

    budget = cnt * 20 + 40;
    for (int i = 0; i < cnt; i++) exp_q.push_back(word_at(sel, (base + i) % DEPTH));

    @(posedge clk); #1;
    start     = 1'b1;
    sram_sel  = sel;
    base_addr = AW'(base);
    word_cnt  = (AW + 1)'(cnt);
    ready_i   = ($urandom_range(99) < rdy_pct);

    while (1) begin
      @(negedge clk);
      chk("cenb_unsel", 64'(sel ? CENB_1 : CENB_2), 64'(1));
      if ((sel ? CENB_2 : CENB_1) == 1'b0) begin
        chk("read_addr", 64'(AB), 64'((base + reads) % DEPTH));
        if (first_read < 0) first_read = cyc;
        last_read = cyc;
        reads++;
        chk("read_not_excess", 64'(reads <= cnt), 64'(1));
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(valid_o), 64'(1));
        chk("hold_data", 64'(data_o_DRAM), 64'(prev_data));
      end
      if (valid_o && first_valid < 0) first_valid = cyc;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got 0x%0h with none expected", data_o_DRAM);
        end else begin
          exp_w = exp_q.pop_front();
          chk("word", 64'(data_o_DRAM), 64'(exp_w));
        end
        pops++;
      end
      chk("outstanding", 64'((reads - pops) <= 2), 64'(1));
      chk("busy_done_excl", 64'(busy && done), 64'(0));
      if (cyc == 1) chk("busy_run", 64'(busy), 64'(cnt > 0));
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o_DRAM;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end

      if (rst_after >= 0 && pops >= rst_after) begin
        @(posedge clk); #1;
        start   = 1'b0;
        ready_i = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        return;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= budget) begin
        tests++;
        fails++;
        $display("FAIL timeout: no done after %0d cycles, required within %0d", cyc, budget);
        break;
      end

      @(posedge clk); #1;
      cyc++;
      start = (cyc == mid_start_cyc);
      if (start) begin
        sram_sel  = ~sel;
        base_addr = '0;
        word_cnt  = (AW + 1)'(2);
      end
      ready_i = ($urandom_range(99) < rdy_pct);
    end

    start   = 1'b0;
    ready_i = 1'b0;
    chk("reads_total", 64'(reads), 64'(cnt));
    chk("words_total", 64'(pops), 64'(cnt));
    chk("done_pulses", 64'(dones), 64'(1));
    chk("busy_after", 64'(busy), 64'(0));
    if (exp_done >= 0) begin
      chk("done_cycle", 64'(done_cyc), 64'(exp_done));
      chk("first_valid", 64'(first_valid), 64'(cnt == 0 ? -1 : 3));
      chk("first_read", 64'(first_read), 64'(cnt == 0 ? -1 : 1));
      chk("last_read", 64'(last_read), 64'(cnt == 0 ? -1 : cnt));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = DW'($urandom);
      mem2[i] = DW'($urandom);
    end
    rst       = 1'b1;
    start     = 1'b0;
    sram_sel  = 1'b0;
    base_addr = '0;
    word_cnt  = '0;
    ready_i   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // With ready held high a drain of N>0 words finishes in cycle N+4;
    // an empty drain goes straight to DONE in cycle 1.
    vecs[0] = '{1'b0, 'h010,    8, 100,   12};
    vecs[1] = '{1'b1, 'h7FE,    4, 100,    8};
    vecs[2] = '{1'b0, 'h123,   16,  50,   -1};
    vecs[3] = '{1'b1, 'h7F0,    0, 100,    1};
    vecs[4] = '{1'b1, 'h3FF,    1, 100,    5};
    vecs[5] = '{1'b0, 'h000, 2048, 100, 2052};

    foreach (vecs[i]) begin
      run_drain(vecs[i].sel, vecs[i].base, vecs[i].cnt, vecs[i].rdy_pct,
                vecs[i].exp_done, -1, -1);
    end

    repeat (8) begin
      run_drain(1'($urandom_range(1)), int'($urandom_range(DEPTH - 1)),
                int'($urandom_range(40)), int'($urandom_range(100, 30)), -1, -1, -1);
    end

    // Conflicting start mid-drain, then reset after five words, then recover.
    run_drain(1'b0, 'h100, 20, 100, -1, 3, 5);
    run_drain(1'b1, 'h055, 3, 100, 7, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fsram_drain
`default_nettype wire
